hub75_capture: RTL and testbench

- Panel-side receiver for the HUB75 LED panel interface; the receiving end of the ledpanel driver.
- Oversamples PANEL_* on CLK12MHZ, rebuilds shift-register/latch/row-select behaviour of a 32x32 panel, commits each displayed row into a capture RAM.
- CPU or testbench reads back the frame through a registered read port.
- Sticky protocol-error flags and a frame counter for in-system/board-level verification.

---
 rtl/hub75_capture.sv | 178 +++++++++++++++++
 tb/tb_hub75_capture.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 panel-side receiver with a row capture RAM
//
// Oversamples the HUB75 bus on CLK12MHZ. It rebuilds the shift register,
// the latch and the row select of a 32x32 panel, and commits each displayed
// row into a capture RAM that can be read back.
//
// Ports:
//   CLK12MHZ, resetn          capture clock, synchronous active-low reset
//   PANEL_R0/G0/B0            top-half colour bits
//   PANEL_R1/G1/B1            bottom-half colour bits
//   PANEL_A..PANEL_D          row-pair select, D is the MSB
//   PANEL_CLK                 serial data clock
//   PANEL_STB                 latch strobe, active high
//   PANEL_OE                  output enable, active low
//   rd_addr_x, rd_addr_y      read column and read row (0..31)
//   rd_data                   {R,G,B} at the read address, 1-cycle latency
//   frame_count               number of completed frames
//   clk_count_err, overrun    sticky protocol-error flags
//   clear_status              clears both sticky flags
module hub75_capture #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 16,
  parameter int FCW   = 16
) (
  input  logic           CLK12MHZ,
  input  logic           resetn,
  input  logic           PANEL_R0,
  input  logic           PANEL_G0,
  input  logic           PANEL_B0,
  input  logic           PANEL_R1,
  input  logic           PANEL_G1,
  input  logic           PANEL_B1,
  input  logic           PANEL_A,
  input  logic           PANEL_B,
  input  logic           PANEL_C,
  input  logic           PANEL_D,
  input  logic           PANEL_CLK,
  input  logic           PANEL_STB,
  input  logic           PANEL_OE,
  input  logic [4:0]     rd_addr_x,
  input  logic [4:0]     rd_addr_y,
  output logic [2:0]     rd_data,
  output logic [FCW-1:0] frame_count,
  output logic           clk_count_err,
  output logic           overrun,
  input  logic           clear_status
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(ROWS);

  // Synchroniser bit order: {R0,G0,B0,R1,G1,B1,D,C,B,A,CLK,STB,OE}.
  // The idle value is 0 everywhere except OE, which idles high.
  localparam logic [12:0] SYNC_IDLE = 13'b0_0000_0000_0001;

  typedef enum logic {IDLE, COMMIT} state_t;

  logic [12:0]          sync1, sync2;
  logic [2:0]           sync3;
  logic                 clk_rise, stb_rise, oe_fall;
  logic [5:0]           sample;
  logic [3:0]           row_sel;
  logic [6*WIDTH-1:0]   shreg, shreg_nxt, latch_q;
  logic [5:0]           shcnt, shcnt_nxt;
  logic                 latch_valid;
  state_t               state;
  logic [ROW_W-1:0]     row, last_row;
  logic [COL_W-1:0]     col;
  logic [5:0]           mem [ROWS*WIDTH];

  // All 13 inputs go through the same two stages, so the data stays aligned
  // with the clock and strobe edges. A third copy of the control bits is
  // kept for edge detection.
  always_ff @(posedge CLK12MHZ) begin
    if (!resetn) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
      sync3 <= 3'b001;
    end else begin
      sync1 <= {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1,
                PANEL_D, PANEL_C, PANEL_B, PANEL_A,
                PANEL_CLK, PANEL_STB, PANEL_OE};
      sync2 <= sync1;
      sync3 <= sync2[2:0];
    end
  end

  assign clk_rise = sync2[2] & ~sync3[2];
  assign stb_rise = sync2[1] & ~sync3[1];
  assign oe_fall  = ~sync2[0] & sync3[0];
  assign sample   = sync2[12:7];
  assign row_sel  = sync2[6:3];

  // New samples enter at column WIDTH-1. The strobe latches the post-shift
  // value, so a clock edge that lands in the same cycle as the strobe is
  // included in the latched row.
  always_comb begin
    shreg_nxt = shreg;
    shcnt_nxt = shcnt;
    if (clk_rise) begin
      shreg_nxt = {sample, shreg[6*WIDTH-1:6]};
      if (shcnt != 6'd63) shcnt_nxt = shcnt + 6'd1;
    end
  end

  always_ff @(posedge CLK12MHZ) begin
    shreg <= shreg_nxt;
    if (stb_rise) latch_q <= shreg_nxt;
  end

  always_ff @(posedge CLK12MHZ) begin
    if (!resetn) begin
      state         <= IDLE;
      latch_valid   <= 1'b0;
      shcnt         <= 6'd0;
      last_row      <= ROW_W'(ROWS - 1);
      row           <= '0;
      col           <= '0;
      frame_count   <= '0;
      clk_count_err <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      shcnt <= stb_rise ? 6'd0 : shcnt_nxt;

      // A set event in the same cycle as clear_status takes priority.
      if (stb_rise && shcnt_nxt != 6'(WIDTH)) clk_count_err <= 1'b1;
      else if (clear_status)                  clk_count_err <= 1'b0;

      if (stb_rise && state == COMMIT) overrun <= 1'b1;
      else if (clear_status)           overrun <= 1'b0;

      case (state)
        IDLE: begin
          // An OE edge with no fresh latch is a PWM re-display of the same
          // data, so it is ignored.
          if (oe_fall && latch_valid) begin
            state       <= COMMIT;
            row         <= row_sel[ROW_W-1:0];
            col         <= '0;
            latch_valid <= 1'b0;
            last_row    <= row_sel[ROW_W-1:0];
            if (row_sel[ROW_W-1:0] == '0 && last_row == ROW_W'(ROWS - 1))
              frame_count <= frame_count + FCW'(1);
          end
        end
        COMMIT: begin
          col <= col + COL_W'(1);
          if (col == COL_W'(WIDTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // This assignment comes last so that a strobe wins over the clear
      // that a commit start performs.
      if (stb_rise) latch_valid <= 1'b1;
    end
  end

  // Columns are written straight from the live latch. A strobe that arrives
  // mid-commit therefore redirects the remaining columns to the new data.
  always_ff @(posedge CLK12MHZ) begin
    if (resetn && state == COMMIT)
      mem[{row, col}] <= latch_q[col*6 +: 6];
  end

  // Reads are registered. A read and a write to the same address in the
  // same cycle return the old contents.
  always_ff @(posedge CLK12MHZ) begin
    if (!resetn) begin
      rd_data <= 3'b000;
    end else if (rd_addr_y[ROW_W]) begin
      rd_data <= mem[{rd_addr_y[ROW_W-1:0], rd_addr_x[COL_W-1:0]}][2:0];
    end else begin
      rd_data <= mem[{rd_addr_y[ROW_W-1:0], rd_addr_x[COL_W-1:0]}][5:3];
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - self-checking bench for hub75_capture
module tb_hub75_capture;

  logic        CLK12MHZ = 1'b0;
  logic        resetn = 1'b0;
  logic        PANEL_R0 = 0, PANEL_G0 = 0, PANEL_B0 = 0;
  logic        PANEL_R1 = 0, PANEL_G1 = 0, PANEL_B1 = 0;
  logic        PANEL_A = 0, PANEL_B = 0, PANEL_C = 0, PANEL_D = 0;
  logic        PANEL_CLK = 0, PANEL_STB = 0, PANEL_OE = 1;
  logic [4:0]  rd_addr_x = 0, rd_addr_y = 0;
  logic [2:0]  rd_data;
  logic [15:0] frame_count;
  logic        clk_count_err, overrun;
  logic        clear_status = 0;

  always #5 CLK12MHZ = ~CLK12MHZ;

  hub75_capture #(.WIDTH(32), .ROWS(16), .FCW(16)) dut (
    .CLK12MHZ(CLK12MHZ), .resetn(resetn),
    .PANEL_R0(PANEL_R0), .PANEL_G0(PANEL_G0), .PANEL_B0(PANEL_B0),
    .PANEL_R1(PANEL_R1), .PANEL_G1(PANEL_G1), .PANEL_B1(PANEL_B1),
    .PANEL_A(PANEL_A), .PANEL_B(PANEL_B), .PANEL_C(PANEL_C), .PANEL_D(PANEL_D),
    .PANEL_CLK(PANEL_CLK), .PANEL_STB(PANEL_STB), .PANEL_OE(PANEL_OE),
    .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .rd_data(rd_data),
    .frame_count(frame_count), .clk_count_err(clk_count_err),
    .overrun(overrun), .clear_status(clear_status)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the panel receiver
  logic [5:0] sh_m [32];
  logic [5:0] latch_m [32];
  logic [5:0] mem_m [512];
  bit         lv_m = 0;
  int         last_row_m = 15;
  int         fc_m = 0;
  int         cnt_m = 0;
  bit         err_m = 0;
  bit         ovr_m = 0;

  logic [2:0] exp_q [$];
  logic [2:0] got_q [$];

  task automatic step(input int n);
    repeat (n) @(negedge CLK12MHZ);
  endtask

  task automatic shift_sample(input logic [5:0] s);
    {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1} = s;
    step(1);
    PANEL_CLK = 1;
    step(1);
    PANEL_CLK = 0;
    for (int i = 0; i < 31; i++) sh_m[i] = sh_m[i+1];
    sh_m[31] = s;
    if (cnt_m < 63) cnt_m++;
  endtask

  task automatic strobe();
    PANEL_STB = 1;
    step(1);
    PANEL_STB = 0;
    step(3);
    latch_m = sh_m;
    lv_m = 1;
    if (cnt_m != 32) err_m = 1;
    cnt_m = 0;
  endtask

  task automatic set_row(input int r);
    {PANEL_D, PANEL_C, PANEL_B, PANEL_A} = 4'(r);
  endtask

  task automatic model_commit(input int r);
    if (lv_m) begin
      for (int c = 0; c < 32; c++) mem_m[r*32 + c] = latch_m[c];
      lv_m = 0;
      if (r == 0 && last_row_m == 15) fc_m = (fc_m + 1) % 65536;
      last_row_m = r;
    end
  endtask

  task automatic commit(input int r);
    set_row(r);
    PANEL_OE = 0;
    step(40);
    PANEL_OE = 1;
    step(3);
    model_commit(r);
  endtask

  task automatic pulse_clear();
    clear_status = 1;
    step(1);
    clear_status = 0;
    step(2);
    err_m = 0;
    ovr_m = 0;
  endtask

  // Issue a full row of reads: expected values go to exp_q as each address
  // is driven, and returned data goes to got_q one cycle later.
  task automatic read_row(input int y);
    logic [5:0] w;
    for (int x = 0; x < 32; x++) begin
      rd_addr_x = 5'(x);
      rd_addr_y = 5'(y);
      w = mem_m[(y % 16)*32 + x];
      exp_q.push_back(y < 16 ? w[5:3] : w[2:0]);
      step(1);
      got_q.push_back(rd_data);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    step(3);
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    checks++;
    if (clk_count_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b want 00", clk_count_err, overrun);
    end
    checks++;
    if (rd_data !== 3'b000) begin errors++; $display("FAIL reset_rd_data got %b want 000", rd_data); end
    resetn = 1;
    step(2);
  endtask

  task automatic test_basic_row();
    logic [2:0] e, g;
    for (int k = 0; k < 32; k++) shift_sample(6'b100001);
    strobe();
    commit(3);
    read_row(3);
    read_row(19);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic_row_read got %b want %b", g, e); end
    end
    checks++;
    if (clk_count_err !== 1'b0) begin errors++; $display("FAIL basic_clk_err got %b want 0", clk_count_err); end
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL basic_fc got %0d want %0d", frame_count, fc_m); end
  endtask

  task automatic test_frame_count();
    logic [2:0] e, g;
    for (int k = 0; k < 32; k++) shift_sample((k % 2) ? 6'b010000 : 6'b000000);
    strobe();
    commit(15);
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL fc_row15 got %0d want %0d", frame_count, fc_m); end
    for (int k = 0; k < 32; k++) shift_sample((k % 2) ? 6'b010000 : 6'b000000);
    strobe();
    set_row(0);
    PANEL_OE = 0;
    step(2);
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL fc_before_entry got %0d want %0d", frame_count, fc_m); end
    step(1);
    model_commit(0);
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL fc_at_entry got %0d want %0d", frame_count, fc_m); end
    step(37);
    PANEL_OE = 1;
    step(3);
    read_row(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL row0_read got %b want %b", g, e); end
    end
  endtask

  task automatic test_no_restrobe();
    logic [2:0] e, g;
    commit(3);
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL norestb_fc got %0d want %0d", frame_count, fc_m); end
    read_row(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL norestb_read got %b want %b", g, e); end
    end
  endtask

  task automatic test_clk_count_err();
    for (int k = 0; k < 31; k++) shift_sample(6'(k));
    strobe();
    checks++;
    if (clk_count_err !== err_m) begin errors++; $display("FAIL err_31 got %b want %b", clk_count_err, err_m); end
    pulse_clear();
    checks++;
    if (clk_count_err !== err_m) begin errors++; $display("FAIL err_clear got %b want %b", clk_count_err, err_m); end
    for (int k = 0; k < 33; k++) shift_sample(6'(k));
    strobe();
    checks++;
    if (clk_count_err !== err_m) begin errors++; $display("FAIL err_33 got %b want %b", clk_count_err, err_m); end
  endtask

  task automatic test_overrun();
    logic [2:0] e, g;
    pulse_clear();
    for (int k = 0; k < 32; k++) shift_sample(6'(k*5 + 1));
    strobe();
    for (int k = 0; k < 32; k++) shift_sample(~6'(k*5 + 1));
    set_row(5);
    PANEL_OE = 0;
    step(10);
    PANEL_STB = 1;
    step(1);
    PANEL_STB = 0;
    step(35);
    PANEL_OE = 1;
    step(3);
    // Columns 0..9 come from the old latch, the rest from the new one.
    for (int c = 0; c < 10; c++) mem_m[5*32 + c] = latch_m[c];
    latch_m = sh_m;
    for (int c = 10; c < 32; c++) mem_m[5*32 + c] = latch_m[c];
    lv_m = 1;
    ovr_m = 1;
    if (cnt_m != 32) err_m = 1;
    cnt_m = 0;
    last_row_m = 5;
    checks++;
    if (overrun !== ovr_m) begin errors++; $display("FAIL overrun got %b want %b", overrun, ovr_m); end
    checks++;
    if (clk_count_err !== err_m) begin errors++; $display("FAIL ovr_clk_err got %b want %b", clk_count_err, err_m); end
    read_row(5);
    read_row(21);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL overrun_read got %b want %b", g, e); end
    end
  endtask

  task automatic test_reset_mid_commit();
    logic [2:0] e, g;
    set_row(3);
    PANEL_OE = 0;
    step(15);
    resetn = 0;
    step(1);
    for (int c = 0; c < 12; c++) mem_m[3*32 + c] = latch_m[c];
    lv_m = 0; fc_m = 0; ovr_m = 0; err_m = 0; last_row_m = 15; cnt_m = 0;
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_fc got %0d want 0", frame_count); end
    checks++;
    if (overrun !== 1'b0 || clk_count_err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got %b%b want 00", overrun, clk_count_err);
    end
    resetn = 1;
    // OE is still low; after reset the synchroniser sees a falling edge,
    // which must be ignored because the latch is no longer valid.
    step(40);
    PANEL_OE = 1;
    step(3);
    read_row(3);
    read_row(19);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL midrst_read got %b want %b", g, e); end
    end
    checks++;
    if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL midrst_fc_after got %0d want %0d", frame_count, fc_m); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin sh_m[i] = '0; latch_m[i] = '0; end
    for (int i = 0; i < 512; i++) mem_m[i] = '0;
    test_reset();
    test_basic_row();
    test_frame_count();
    test_no_restrobe();
    test_clk_count_err();
    test_overrun();
    test_reset_mid_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
